// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a two-entry skid buffer.
// Upstream ready comes from registers only, so back-pressure never forms a
// combinational path across the stage. A synchronous flush kills held and
// incoming entries. Control fields read as NOP whenever the stage is empty.
// Saturating stall and bubble counters support performance analysis.
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 134,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Occupancy states. The encoding keeps bit 0 as "main valid" and bit 1 as
    // "skid valid", so the illegal skid-only case is the unused code 2'b10.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_nextState;
    logic [CTRL_W-1:0]   r_mainCtrl;
    logic [DATA_W-1:0]   r_mainData;
    logic [CTRL_W-1:0]   r_skidCtrl;
    logic [DATA_W-1:0]   r_skidData;
    logic [CNT_W-1:0]    r_stallCnt;
    logic [CNT_W-1:0]    r_bubbleCnt;
    logic                w_mainValid;
    logic                w_skidValid;
    logic                w_acc;
    logic                w_deq;
    logic                w_loadMainIn;
    logic                w_loadMainSkid;
    logic                w_loadSkid;

    assign w_mainValid = (r_state != EMPTY);
    assign w_skidValid = (r_state == FULL);

    assign in_ready   = !w_skidValid && !reset;
    assign w_acc      = in_valid && in_ready;
    assign w_deq      = w_mainValid && out_ready;

    assign out_valid  = w_mainValid;
    assign out_ctrl   = w_mainValid ? r_mainCtrl : '0;
    assign out_data   = r_mainData;
    assign occupancy  = w_mainValid ? (w_skidValid ? 2'd2 : 2'd1) : 2'd0;
    assign stall_cnt  = r_stallCnt;
    assign bubble_cnt = r_bubbleCnt;

    // Occupancy state register; reset drops every held entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next occupancy and which registers load; flush overrides every load.
    always_comb begin
        w_nextState    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_loadMainIn = 1'b1;
                    w_nextState  = ONE;
                end
            end
            ONE: begin
                if (w_deq && w_acc) begin
                    w_loadMainIn = 1'b1;
                end else if (w_deq) begin
                    w_nextState = EMPTY;
                end else if (w_acc) begin
                    w_loadSkid  = 1'b1;
                    w_nextState = FULL;
                end
            end
            FULL: begin
                if (w_deq) begin
                    w_loadMainSkid = 1'b1;
                    w_nextState    = ONE;
                end
            end
            default: begin
                w_nextState = EMPTY;
            end
        endcase
        if (flush) begin
            w_nextState    = EMPTY;
            w_loadMainIn   = 1'b0;
            w_loadMainSkid = 1'b0;
            w_loadSkid     = 1'b0;
        end
    end

    // Payload registers; they keep their contents when the stage empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mainCtrl <= '0;
            r_mainData <= '0;
            r_skidCtrl <= '0;
            r_skidData <= '0;
        end else begin
            if (w_loadMainIn) begin
                r_mainCtrl <= in_ctrl;
                r_mainData <= in_data;
            end else if (w_loadMainSkid) begin
                r_mainCtrl <= r_skidCtrl;
                r_mainData <= r_skidData;
            end
            if (w_loadSkid) begin
                r_skidCtrl <= in_ctrl;
                r_skidData <= in_data;
            end
        end
    end

    // Saturating performance counters, sampled on the pre-update state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt  <= '0;
            r_bubbleCnt <= '0;
        end else begin
            if (w_mainValid && !out_ready && (r_stallCnt != CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + CNT_ONE;
            end
            if (!w_mainValid && (r_bubbleCnt != CNT_MAX)) begin
                r_bubbleCnt <= r_bubbleCnt + CNT_ONE;
            end
        end
    end

    // Simulation guard: a skid entry without a main entry must never exist.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_state == EMPTY || r_state == ONE || r_state == FULL);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a directed vector table, hand-written
// corner-case sequences and a randomized run, all compared against a
// queue-based reference model of a two-deep FIFO stage.
module tb_pipe_stage_skid;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 134;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              inValid;
    logic              inReady;
    logic [CTRL_W-1:0] inCtrl;
    logic [DATA_W-1:0] inData;
    logic              outValid;
    logic              outReady;
    logic [CTRL_W-1:0] outCtrl;
    logic [DATA_W-1:0] outData;
    logic [1:0]        occupancy;
    logic [15:0]       stallCnt;
    logic [15:0]       bubbleCnt;

    logic              satInReady;
    logic              satOutValid;
    logic [CTRL_W-1:0] satOutCtrl;
    logic [DATA_W-1:0] satOutData;
    logic [1:0]        satOccupancy;
    logic [3:0]        satStallCnt;
    logic [3:0]        satBubbleCnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } entry_t;

    entry_t            modelQ[$];
    logic [DATA_W-1:0] modelLastData = '0;
    int                stallTotal = 0;
    int                bubbleTotal = 0;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic        orr;
        logic [7:0]  c;
        logic [15:0] d;
        logic        expValid;
        logic [7:0]  expCtrl;
        logic [15:0] expData;
        logic [1:0]  expOcc;
        logic        expReady;
        int          expStall;
        int          expBubble;
    } vec_t;

    vec_t vecs[12];

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_ctrl(inCtrl), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_ctrl(outCtrl), .out_data(outData),
        .occupancy(occupancy), .stall_cnt(stallCnt), .bubble_cnt(bubbleCnt)
    );

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dutSat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(satInReady), .in_ctrl(inCtrl), .in_data(inData),
        .out_valid(satOutValid), .out_ready(outReady), .out_ctrl(satOutCtrl), .out_data(satOutData),
        .occupancy(satOccupancy), .stall_cnt(satStallCnt), .bubble_cnt(satBubbleCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    function automatic logic [3:0] sat4(input int n);
        return (n > 15) ? 4'hF : n[3:0];
    endfunction

    function automatic logic [DATA_W-1:0] randData();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a capacity-two FIFO whose head drives the output.
    task automatic modelStep(input logic rst, input logic fl, input logic iv, input logic orr,
                             input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        bit acc;
        bit deq;
        acc = !rst && iv && (modelQ.size() < 2);
        deq = (modelQ.size() > 0) && orr;
        if (rst) begin
            modelQ.delete();
            modelLastData = '0;
            stallTotal = 0;
            bubbleTotal = 0;
        end else begin
            if (modelQ.size() > 0 && !orr) stallTotal++;
            if (modelQ.size() == 0) bubbleTotal++;
            if (fl) begin
                modelQ.delete();
            end else begin
                if (deq) void'(modelQ.pop_front());
                if (acc) modelQ.push_back('{c, d});
            end
            if (modelQ.size() > 0) modelLastData = modelQ[0].d;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic fl, input logic iv, input logic orr,
                                 input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        logic expReady;
        reset    = rst;
        flush    = fl;
        inValid  = iv;
        outReady = orr;
        inCtrl   = c;
        inData   = d;
        #1;
        expReady = !rst && (modelQ.size() < 2);
        check("inReadyPre", DATA_W'(inReady), DATA_W'(expReady));
        check("satInReadyPre", DATA_W'(satInReady), DATA_W'(expReady));
        @(posedge clk);
        modelStep(rst, fl, iv, orr, c, d);
        #1;
    endtask

    task automatic checkOutput();
        logic              expValid;
        logic [CTRL_W-1:0] expCtrl;
        expValid = (modelQ.size() > 0);
        expCtrl  = expValid ? modelQ[0].c : '0;
        check("outValid", DATA_W'(outValid), DATA_W'(expValid));
        check("outCtrl", DATA_W'(outCtrl), DATA_W'(expCtrl));
        check("outData", outData, modelLastData);
        check("occupancy", DATA_W'(occupancy), DATA_W'(modelQ.size()));
        check("inReady", DATA_W'(inReady), DATA_W'(!reset && modelQ.size() < 2));
        check("stallCnt", DATA_W'(stallCnt), DATA_W'(sat16(stallTotal)));
        check("bubbleCnt", DATA_W'(bubbleCnt), DATA_W'(sat16(bubbleTotal)));
        check("satOutValid", DATA_W'(satOutValid), DATA_W'(expValid));
        check("satOutCtrl", DATA_W'(satOutCtrl), DATA_W'(expCtrl));
        check("satOutData", satOutData, modelLastData);
        check("satOccupancy", DATA_W'(satOccupancy), DATA_W'(modelQ.size()));
        check("satStallCnt", DATA_W'(satStallCnt), DATA_W'(sat4(stallTotal)));
        check("satBubbleCnt", DATA_W'(satBubbleCnt), DATA_W'(sat4(bubbleTotal)));
    endtask

    task automatic step(input logic rst, input logic fl, input logic iv, input logic orr,
                        input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        applyStimulus(rst, fl, iv, orr, c, d);
        checkOutput();
    endtask

    initial begin
        // rst fl iv or  ctrl   data   | valid ctrl  data   occ rdy stall bubble
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b0, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 16'h0001, 1'b1, 8'h01, 16'h0001, 2'd1, 1'b1, 0, 1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 16'h0002, 1'b1, 8'h02, 16'h0002, 2'd1, 1'b1, 0, 1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 16'h0003, 1'b1, 8'h03, 16'h0003, 2'd1, 1'b1, 0, 1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 16'h0004, 1'b1, 8'h04, 16'h0004, 2'd1, 1'b1, 0, 1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h0A, 16'h000A, 1'b1, 8'h0A, 16'h000A, 2'd1, 1'b1, 0, 1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h0B, 16'h000B, 1'b1, 8'h0A, 16'h000A, 2'd2, 1'b0, 1, 1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h0C, 16'h000C, 1'b1, 8'h0A, 16'h000A, 2'd2, 1'b0, 2, 1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h0A, 16'h000A, 2'd2, 1'b0, 3, 1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1, 8'h0B, 16'h000B, 2'd1, 1'b1, 3, 1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h000B, 2'd0, 1'b1, 3, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h000B, 2'd0, 1'b1, 3, 2};

        // Streaming, then back-pressure into the skid entry and drain in order.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].orr, vecs[i].c, DATA_W'(vecs[i].d));
            check("vecValid", DATA_W'(outValid), DATA_W'(vecs[i].expValid));
            check("vecCtrl", DATA_W'(outCtrl), DATA_W'(vecs[i].expCtrl));
            check("vecData", outData, DATA_W'(vecs[i].expData));
            check("vecOcc", DATA_W'(occupancy), DATA_W'(vecs[i].expOcc));
            check("vecReady", DATA_W'(inReady), DATA_W'(vecs[i].expReady));
            check("vecStall", DATA_W'(stallCnt), DATA_W'(vecs[i].expStall));
            check("vecBubble", DATA_W'(bubbleCnt), DATA_W'(vecs[i].expBubble));
        end

        // Flush while FULL with an incoming entry: everything is killed.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h11, DATA_W'(16'h0011));
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, DATA_W'(16'h0022));
        check("fullOcc", DATA_W'(occupancy), DATA_W'(2'd2));
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h33, DATA_W'(16'h0033));
        check("flushValid", DATA_W'(outValid), DATA_W'(1'b0));
        check("flushCtrl", DATA_W'(outCtrl), DATA_W'(8'h00));
        check("flushOcc", DATA_W'(occupancy), DATA_W'(2'd0));
        check("flushReady", DATA_W'(inReady), DATA_W'(1'b1));
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, '0);
        check("flushNoLeak", DATA_W'(outValid), DATA_W'(1'b0));

        // Bubble masking: control reads zero, data holds the last entry.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, DATA_W'(16'h0055));
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, '0);
        check("maskValid", DATA_W'(outValid), DATA_W'(1'b0));
        check("maskCtrl", DATA_W'(outCtrl), DATA_W'(8'h00));
        check("maskData", outData, DATA_W'(16'h0055));

        // Reset together with flush while FULL with stall count five.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hA1, DATA_W'(16'h00A1));
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, DATA_W'(16'h00B2));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
        check("preResetStall", DATA_W'(stallCnt), DATA_W'(16'd5));
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, DATA_W'(16'h00C3));
        check("rstValid", DATA_W'(outValid), DATA_W'(1'b0));
        check("rstOcc", DATA_W'(occupancy), DATA_W'(2'd0));
        check("rstData", outData, '0);
        check("rstStall", DATA_W'(stallCnt), DATA_W'(16'd0));
        check("rstBubble", DATA_W'(bubbleCnt), DATA_W'(16'd0));
        check("rstReady", DATA_W'(inReady), DATA_W'(1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
        check("postRstReady", DATA_W'(inReady), DATA_W'(1'b1));

        // Counter saturation on the narrow-counter instance.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
        check("satBubble15", DATA_W'(satBubbleCnt), DATA_W'(4'd15));
        check("wideBubble20", DATA_W'(bubbleCnt), DATA_W'(16'd20));

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                 8'($urandom()), randData());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic parametrised pipeline-stage register replacing the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is register-driven and back-pressure does not form a combinational path across the stage.
- Supports synchronous flush for branch/exception kill.
- Forces control fields to NOP whenever the stage holds a bubble.
- Provides saturating stall and bubble counters for performance analysis.

Parameters:
CTRL_W, 8, width of control bundle (RegWrite, MemtoReg, MemRead, MemWrite, Branch, bne, ...); zeroed on bubble.
DATA_W, 134, width of data bundle (immediate, ALU result, rd2, branch target, write-reg number, zero flag); not masked.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  kill all held and incoming entries this cycle.
in_valid  in  1  upstream entry present.
in_ready  out  1  stage can accept an entry this cycle.
in_ctrl  in  CTRL_W  upstream control bundle.
in_data  in  DATA_W  upstream data bundle.
out_valid  out  1  output entry present.
out_ready  in  1  downstream accepts output this cycle.
out_ctrl  out  CTRL_W  output control bundle; all zero when out_valid=0.
out_data  out  DATA_W  output data bundle.
occupancy  out  2  number of held entries (0..2).
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating.

Behaviour:
- Clock is clk; reset is reset, synchronous, active-high. All state changes occur on the rising edge of clk.
- Storage:
  - main entry: main_v, main_c, main_d; drives out_*.
  - skid entry: skid_v, skid_c, skid_d.
- in_ready = !skid_v && !reset. It depends only on registers and reset, never on out_ready.
- out_valid = main_v. out_ctrl = main_v ? main_c : 0. out_data = main_d, which holds its last value when invalid.
- occupancy = main_v + skid_v. Legal states:
  - EMPTY (0,0)
  - ONE (1,0)
  - FULL (1,1)
  - (0,1) is illegal and must never occur; assert in simulation.
- Events: acc = in_valid && in_ready; deq = main_v && out_ready.
- Transitions when flush=0:
  - EMPTY: if acc, load main from input and go to ONE; otherwise stay.
  - ONE, deq and acc: main loads input; stay ONE.
  - ONE, deq only: go to EMPTY.
  - ONE, acc only: skid loads input; go to FULL.
  - ONE, neither: hold.
  - FULL: acc is impossible (in_ready=0). If deq, main loads skid, skid_v clears, go to ONE; otherwise hold.
- Order is strictly FIFO; no entry is duplicated or dropped unless flushed.
- Latency: an entry accepted at edge N appears on out_* after edge N (one cycle) when the stage was EMPTY, or ONE with deq.
- Throughput: one entry per cycle when out_ready is held high.
- flush=1 (priority below reset):
  - main_v and skid_v clear.
  - Any acc that cycle is discarded; the upstream sees it as consumed because in_ready was 1.
  - A deq in the same cycle still counts as delivered downstream.
  - Data registers are unchanged; counters are unaffected.
- Reset:
  - main_v, skid_v, and all ctrl/data registers clear to 0; stall_cnt and bubble_cnt clear to 0.
  - While reset is high: out_valid=0, out_ctrl=0, out_data=0 after the first edge, in_ready=0.
  - Reset mid-transfer drops all entries.
- Counters:
  - Each counter increments by 1 per qualifying cycle (sampled at the edge, pre-update state) and saturates at 2^CNT_W-1 without wrapping.
  - Counting is suppressed during reset.
- Simultaneous flush and reset: reset wins; the result is identical to reset alone.
- No combinational path from out_ready to in_ready. out_* are register outputs, except the ctrl mask AND with main_v.

Test Plan:
1. Streaming: after reset, drive in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each, occupancy stays 1, in_ready stays 1, bubble_cnt=1 (first cycle).
2. Back-pressure/skid: with entries 0xA then 0xB accepted, hold out_ready=0 for 3 cycles -> occupancy=2, in_ready=0 after second accept, out_data=0xA held, stall_cnt=3. Then raise out_ready -> 0xA, then 0xB delivered in order, in_ready returns to 1 one cycle after the first deq.
3. Flush in FULL state with in_valid=1: assert flush one cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. The flushed input never appears at the output.
4. Bubble masking: in_ctrl=0xFF, in_data=0x55 accepted and dequeued, then no input -> out_ctrl=0x00 while out_data still 0x55 and out_valid=0.
5. Reset mid-operation: FULL with stall_cnt=5, assert reset one cycle together with flush -> out_valid=0, occupancy=0, out_data=0, stall_cnt=0, bubble_cnt=0, in_ready=0 during reset and 1 afterward.
6. Counter saturation with CNT_W=4: hold EMPTY for 20 cycles -> bubble_cnt reaches 15 and stays 15.
